// File: rtl/seg_display_if.sv
// Load channel between the word producer and the display driver.
// Producer strobes a word in; the driver reports pending/commit status.
interface seg_display_if;
  logic [15:0] value;
  logic [3:0]  dp_mask;
  logic        value_valid;
  logic        pending;
  logic        value_ack;

  modport master (
    output value, dp_mask, value_valid,
    input  pending, value_ack
  );

  modport slave (
    input  value, dp_mask, value_valid,
    output pending, value_ack
  );
endinterface

// File: rtl/seg_display_driver.sv
// Four-digit multiplexed hex display driver, active-low common anode.
// Loads are buffered and committed only at frame boundaries (no tearing).
module seg_display_driver #(
  parameter int REFRESH_DIV  = 1024,
  parameter int BLANK_CYCLES = 16
) (
  input  logic         CLK,
  input  logic         RST,
  seg_display_if.slave ld,
  input  logic         blank_lz,
  output logic [6:0]   SEG,
  output logic         DP,
  output logic [3:0]   AN
);

  localparam int PW = $clog2(REFRESH_DIV);
  localparam logic [PW-1:0] TC = PW'(REFRESH_DIV - 1);
  localparam logic [PW-1:0] BL = PW'(BLANK_CYCLES);

  logic [PW-1:0] presc_q, presc_d;
  logic [1:0]    idx_q, idx_d;
  logic [15:0]   buf_q, buf_d;
  logic [3:0]    bdp_q, bdp_d;
  logic          pend_q, pend_d;
  logic [15:0]   disp_q, disp_d;
  logic [3:0]    dpr_q, dpr_d;
  logic          ack_q, ack_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;
  logic [3:0]    an_q, an_d;

  logic          tc;
  logic          commit;
  logic [3:0]    nib;
  logic          lz;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // Scan timing, load buffer and frame-boundary commit.
  always_comb begin
    tc      = (presc_q == TC);
    commit  = tc && (idx_q == 2'd3) && pend_q;
    presc_d = tc ? '0 : presc_q + PW'(1);
    idx_d   = tc ? idx_q + 2'd1 : idx_q;
    buf_d   = buf_q;
    bdp_d   = bdp_q;
    pend_d  = pend_q;
    disp_d  = disp_q;
    dpr_d   = dpr_q;
    ack_d   = commit;
    if (commit) begin
      disp_d = buf_q;
      dpr_d  = bdp_q;
      pend_d = 1'b0;
    end
    if (ld.value_valid) begin
      buf_d  = ld.value;
      bdp_d  = ld.dp_mask;
      pend_d = 1'b1;
    end
  end

  // Digit decode for the slot currently being scanned.
  always_comb begin
    nib = 4'h0;
    lz  = 1'b0;
    case (idx_q)
      2'd0: nib = disp_q[3:0];
      2'd1: begin
        nib = disp_q[7:4];
        lz  = (disp_q[15:4] == 12'h0);
      end
      2'd2: begin
        nib = disp_q[11:8];
        lz  = (disp_q[15:8] == 8'h0);
      end
      default: begin
        nib = disp_q[15:12];
        lz  = (disp_q[15:12] == 4'h0);
      end
    endcase
    an_d  = 4'hF;
    seg_d = 7'h7F;
    dp_d  = 1'b1;
    if (presc_q >= BL) begin
      an_d        = 4'hF;
      an_d[idx_q] = 1'b0;
      seg_d       = (blank_lz && lz) ? 7'h7F : hex7(nib);
      dp_d        = ~dpr_q[idx_q];
    end
  end

  // State and registered outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      presc_q <= '0;
      idx_q   <= 2'd0;
      buf_q   <= 16'h0;
      bdp_q   <= 4'h0;
      pend_q  <= 1'b0;
      disp_q  <= 16'h0;
      dpr_q   <= 4'h0;
      ack_q   <= 1'b0;
      seg_q   <= 7'h7F;
      dp_q    <= 1'b1;
      an_q    <= 4'hF;
    end else begin
      presc_q <= presc_d;
      idx_q   <= idx_d;
      buf_q   <= buf_d;
      bdp_q   <= bdp_d;
      pend_q  <= pend_d;
      disp_q  <= disp_d;
      dpr_q   <= dpr_d;
      ack_q   <= ack_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
      an_q    <= an_d;
    end
  end

  assign ld.pending   = pend_q;
  assign ld.value_ack = ack_q;
  assign SEG          = seg_q;
  assign DP           = dp_q;
  assign AN           = an_q;

endmodule

// File: tb/tb_seg_display_driver.sv
// Randomized scoreboard bench for seg_display_driver.
// A time-based reference model predicts every output cycle.
module tb_seg_display_driver;

  localparam int RD = 8;
  localparam int BC = 2;
  localparam int FR = 4 * RD;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       pend;
    logic       ack;
  } exp_t;

  logic       clk = 1'b0;
  logic       RST = 1'b0;
  logic       blank_lz = 1'b0;
  logic [6:0] SEG;
  logic       DP;
  logic [3:0] AN;

  seg_display_if ld ();

  seg_display_driver #(
    .REFRESH_DIV (RD),
    .BLANK_CYCLES(BC)
  ) dut (
    .CLK     (clk),
    .RST     (RST),
    .ld      (ld),
    .blank_lz(blank_lz),
    .SEG     (SEG),
    .DP      (DP),
    .AN      (AN)
  );

  always #5 clk = ~clk;

  logic [6:0] HEX [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  exp_t q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;

  bit          armed = 0;
  int          mt = 0;
  logic [15:0] mdisp = 0, mbuf = 0;
  logic [3:0]  mdp = 0, mbdp = 0;
  bit          mpend = 0;

  // Reference model: slot/phase derived from elapsed time since reset.
  always @(posedge clk) begin
    exp_t e;
    int slot, phase;
    logic [15:0] hi;
    if (RST) begin
      armed = 1; mt = 0; mpend = 0;
      mdisp = 0; mdp = 0;
      e.an = 4'hF; e.seg = 7'h7F; e.dp = 1'b1;
      e.pend = 1'b0; e.ack = 1'b0;
      q.push_back(e);
    end else if (armed) begin
      slot  = (mt / RD) % 4;
      phase = mt % RD;
      hi    = mdisp >> (4 * slot);
      e.an = 4'hF; e.seg = 7'h7F; e.dp = 1'b1;
      if (phase >= BC) begin
        e.an = ~(4'b0001 << slot);
        if (blank_lz && slot > 0 && hi == 16'h0)
          e.seg = 7'h7F;
        else
          e.seg = HEX[hi[3:0]];
        e.dp = ~mdp[slot];
      end
      e.ack = 1'b0;
      if ((mt % FR) == FR - 1 && mpend) begin
        mdisp = mbuf; mdp = mbdp;
        mpend = 0; e.ack = 1'b1;
      end
      if (ld.value_valid) begin
        mbuf = ld.value; mbdp = ld.dp_mask;
        mpend = 1;
      end
      e.pend = mpend;
      q.push_back(e);
      mt++;
    end
  end

  // Monitor: compare every presented output cycle with the model.
  always @(negedge clk) begin
    exp_t e, g;
    cyc++;
    if (q.size() > 0) begin
      e = q.pop_front();
      g = {AN, SEG, DP, ld.pending, ld.value_ack};
      vectors++;
      if (g !== e) begin
        miscompares++;
        if (miscompares <= 20)
          $display("FAIL outputs cyc %0d: AN/SEG/DP/pend/ack got %h/%b/%b/%b/%b want %h/%b/%b/%b/%b",
                   cyc, g.an, g.seg, g.dp, g.pend, g.ack,
                   e.an, e.seg, e.dp, e.pend, e.ack);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load(input logic [15:0] v, input logic [3:0] m);
    ld.value = v; ld.dp_mask = m; ld.value_valid = 1'b1;
    @(negedge clk);
    ld.value_valid = 1'b0;
  endtask

  task automatic wait_phase(input int p, input string nm);
    int i;
    for (i = 0; i < 2 * FR && (mt % FR) != p; i++)
      @(negedge clk);
    if ((mt % FR) != p) begin
      miscompares++;
      $display("FAIL %s: frame position %0d not reached, at %0d", nm, p, mt % FR);
    end
  endtask

  logic [15:0] masks [4] = '{16'hFFFF, 16'h0FFF, 16'h00FF, 16'h000F};

  initial begin
    ld.value = 16'h0; ld.dp_mask = 4'h0; ld.value_valid = 1'b0;
    @(negedge clk);
    RST = 1'b1; tick(2); RST = 1'b0;
    tick(40);
    wait_phase(3, "load_12af");
    load(16'h12AF, 4'b0100);
    tick(70);
    load(16'h1111, 4'h0); tick(2);
    load(16'h2222, 4'h1);
    tick(70);
    wait_phase(5, "load_0005");
    load(16'h0005, 4'h0);
    wait_phase(FR - 1, "boundary_0007");
    load(16'h0007, 4'h8);
    tick(70);
    blank_lz = 1'b1;
    load(16'h0070, 4'h0);
    tick(70);
    blank_lz = 1'b0;
    tick(40);
    blank_lz = 1'b1;
    load(16'hABCD, 4'hF);
    tick(11);
    RST = 1'b1; tick(1); RST = 1'b0;
    tick(70);
    for (int i = 0; i < 3000; i++) begin
      ld.value_valid = ($urandom_range(0, 15) == 0);
      ld.value = 16'($urandom) & masks[$urandom_range(0, 3)];
      ld.dp_mask = 4'($urandom);
      if ($urandom_range(0, 63) == 0) blank_lz = ~blank_lz;
      RST = ($urandom_range(0, 499) == 0);
      @(negedge clk);
    end
    ld.value_valid = 1'b0; RST = 1'b0;
    tick(3);
    if (vectors < 100) begin
      miscompares++;
      $display("FAIL coverage: vectors %0d, need at least 100", vectors);
    end
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
